// File: rtl/aht10_ctrl.sv
// AHT10 sensor sequencer: power-up wait, calibration init, periodic trigger and 6-byte read-back.
// Drives a byte-level I2C master one command at a time and emits the raw 40-bit humidity/temperature sample.
module aht10_ctrl #(
    parameter int         CLK_FREQ   = 50_000_000,
    parameter int         PWR_UP_MS  = 40,
    parameter int         INIT_MS    = 10,
    parameter int         MEAS_MS    = 80,
    parameter int         PERIOD_MS  = 1000,
    parameter int         RETRY_MS   = 100,
    parameter logic [6:0] SLAVE_ADDR = 7'h38
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i2c_req,
    output logic [3:0]  i2c_cmd,
    output logic [7:0]  i2c_wr_data,
    input  logic [7:0]  i2c_rd_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic [39:0] dout,
    output logic        dout_vld,
    output logic        err
);

    localparam int TICKS_PER_MS = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;

    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_WR    = 4'b0010;
    localparam logic [3:0] C_RD    = 4'b0100;
    localparam logic [3:0] C_STOP  = 4'b1000;

    localparam logic [7:0] ADDR_W = {SLAVE_ADDR, 1'b0};
    localparam logic [7:0] ADDR_R = {SLAVE_ADDR, 1'b1};

    typedef enum logic [3:0] {
        PWRUP, INIT, INITW, TRIG, MEASW, READ, CHECK, PERIODW, ABORT, RETRYW
    } state_t;

    state_t            state, state_nxt;
    logic [31:0]       presc, ms_cnt, wait_ms;
    logic              tick, wait_done;
    logic [2:0]        idx;
    logic              pending, accept, last, set_vld, set_err;
    logic [5:0][7:0]   shadow;

    assign tick   = (presc == 32'(TICKS_PER_MS - 1));
    // A done pulse only counts while a command is actually outstanding.
    assign accept = i2c_done && pending;

    always_comb begin
        wait_ms = 32'd1;
        case (state)
            PWRUP:   wait_ms = 32'(PWR_UP_MS);
            INITW:   wait_ms = 32'(INIT_MS);
            MEASW:   wait_ms = 32'(MEAS_MS);
            PERIODW: wait_ms = 32'(PERIOD_MS);
            RETRYW:  wait_ms = 32'(RETRY_MS);
            default: wait_ms = 32'd1;
        endcase
    end

    assign wait_done = tick && (ms_cnt == wait_ms - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PWRUP;
        else        state <= state_nxt;
    end

    // Command outputs are decoded from state/idx, which hold still until done.
    always_comb begin
        state_nxt   = state;
        i2c_req     = 1'b0;
        i2c_cmd     = '0;
        i2c_wr_data = '0;
        last        = 1'b0;
        set_vld     = 1'b0;
        set_err     = 1'b0;
        case (state)
            PWRUP:   if (wait_done) state_nxt = INIT;
            INITW:   if (wait_done) state_nxt = TRIG;
            MEASW:   if (wait_done) state_nxt = READ;
            PERIODW: if (wait_done) state_nxt = TRIG;
            RETRYW:  if (wait_done) state_nxt = INIT;
            INIT, TRIG: begin
                i2c_req = !pending;
                case (idx)
                    3'd0: begin
                        i2c_cmd     = C_START | C_WR;
                        i2c_wr_data = ADDR_W;
                    end
                    3'd1: begin
                        i2c_cmd     = C_WR;
                        i2c_wr_data = (state == INIT) ? 8'hE1 : 8'hAC;
                    end
                    3'd2: begin
                        i2c_cmd     = C_WR;
                        i2c_wr_data = (state == INIT) ? 8'h08 : 8'h33;
                    end
                    default: begin
                        i2c_cmd     = C_WR | C_STOP;
                        i2c_wr_data = 8'h00;
                        last        = 1'b1;
                    end
                endcase
                if (accept && i2c_nack && i2c_cmd[1]) state_nxt = ABORT;
                else if (accept && last)              state_nxt = (state == INIT) ? INITW : MEASW;
            end
            READ: begin
                i2c_req = !pending;
                if (idx == 3'd0) begin
                    i2c_cmd     = C_START | C_WR;
                    i2c_wr_data = ADDR_R;
                end else if (idx == 3'd6) begin
                    i2c_cmd = C_RD | C_STOP;
                    last    = 1'b1;
                end else begin
                    i2c_cmd = C_RD;
                end
                if (accept && i2c_nack && i2c_cmd[1]) state_nxt = ABORT;
                else if (accept && last)              state_nxt = CHECK;
            end
            CHECK: begin
                if (!shadow[0][3]) begin
                    set_err   = 1'b1;
                    state_nxt = RETRYW;
                end else if (shadow[0][7]) begin
                    // Busy: re-read after another measurement wait, no new trigger.
                    state_nxt = MEASW;
                end else begin
                    set_vld   = 1'b1;
                    state_nxt = PERIODW;
                end
            end
            ABORT: begin
                // NACK on this STOP is deliberately not looked at.
                i2c_req = !pending;
                i2c_cmd = C_STOP;
                if (accept) begin
                    set_err   = 1'b1;
                    state_nxt = RETRYW;
                end
            end
            default: state_nxt = PWRUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            ms_cnt   <= '0;
            idx      <= '0;
            pending  <= 1'b0;
            shadow   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            dout_vld <= set_vld;
            err      <= set_err;
            if (set_vld) dout <= {shadow[1], shadow[2], shadow[3], shadow[4], shadow[5]};

            // Timer and byte index restart on every state entry.
            if (state_nxt != state) begin
                presc  <= '0;
                ms_cnt <= '0;
                idx    <= '0;
            end else begin
                if (tick) begin
                    presc  <= '0;
                    ms_cnt <= ms_cnt + 32'd1;
                end else begin
                    presc <= presc + 32'd1;
                end
                if (accept) idx <= idx + 3'd1;
            end

            if (i2c_req)     pending <= 1'b1;
            else if (accept) pending <= 1'b0;

            if (accept && state == READ) begin
                for (int k = 0; k < 6; k++)
                    if (idx == 3'(k + 1)) shadow[k] <= i2c_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_aht10_ctrl.sv
// Bench for aht10_ctrl: 1 ms per cycle, I2C master model with 3-cycle done latency,
// command and sample scoreboards filled by the scenario tasks and drained by the monitor.
module tb_aht10_ctrl;

    localparam int CLK_FREQ  = 1000;
    localparam int PWR_UP_MS = 40;
    localparam int INIT_MS   = 10;
    localparam int MEAS_MS   = 80;
    localparam int PERIOD_MS = 1000;
    localparam int RETRY_MS  = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2c_req;
    logic [3:0]  i2c_cmd;
    logic [7:0]  i2c_wr_data;
    logic [7:0]  i2c_rd_data = 8'h00;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic [39:0] dout;
    logic        dout_vld;
    logic        err;

    aht10_ctrl #(
        .CLK_FREQ(CLK_FREQ), .PWR_UP_MS(PWR_UP_MS), .INIT_MS(INIT_MS), .MEAS_MS(MEAS_MS),
        .PERIOD_MS(PERIOD_MS), .RETRY_MS(RETRY_MS), .SLAVE_ADDR(7'h38)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i2c_req(i2c_req), .i2c_cmd(i2c_cmd), .i2c_wr_data(i2c_wr_data),
        .i2c_rd_data(i2c_rd_data), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
        .dout(dout), .dout_vld(dout_vld), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, errors = 0;
    logic [11:0] exp_q[$];
    logic [39:0] dout_q[$];
    logic [7:0]  rd_q[$];
    int          req_cyc[$];
    int          done_cyc[$];
    int          req_cnt = 0, vld_cnt = 0, err_cnt = 0, vld_cyc = 0, err_cyc = 0;
    int          lat = 0;
    logic [11:0] cur, e;
    logic [39:0] ed;
    logic [7:0]  nack_byte = 8'h00;
    bit          nack_arm = 1'b0;

    // I2C master model, output monitor and scoreboard drain.
    always @(negedge clk) begin
        i2c_done    = 1'b0;
        i2c_nack    = 1'b0;
        i2c_rd_data = 8'h00;
        if (lat > 0) begin
            if (rst_n) begin
                checks++;
                if ({i2c_cmd, i2c_wr_data} !== cur) begin
                    errors++;
                    $display("FAIL cmd_hold: got %h required %h", {i2c_cmd, i2c_wr_data}, cur);
                end
            end
            lat--;
            if (lat == 0) begin
                i2c_done = 1'b1;
                done_cyc.push_back(cyc);
                if (cur[10]) begin
                    if (rd_q.size() > 0) i2c_rd_data = rd_q.pop_front();
                    else                 i2c_rd_data = 8'hFF;
                end
                if (cur[9] && nack_arm && cur[7:0] == nack_byte) begin
                    i2c_nack = 1'b1;
                    nack_arm = 1'b0;
                end
            end
        end
        if (i2c_req === 1'b1) begin
            cur = {i2c_cmd, i2c_wr_data};
            lat = 3;
            req_cnt++;
            req_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req: got %h at cycle %0d, none required", cur, cyc);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL req_%0d: got %h required %h", req_cnt - 1, cur, e);
                end
            end
        end
        if (dout_vld === 1'b1) begin
            vld_cnt++;
            vld_cyc = cyc;
            checks++;
            if (dout_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dout_vld: dout %h at cycle %0d", dout, cyc);
            end else begin
                ed = dout_q.pop_front();
                if (dout !== ed) begin
                    errors++;
                    $display("FAIL dout: got %h required %h", dout, ed);
                end
            end
        end
        if (err === 1'b1) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic push_seq(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back({4'h3, 8'h70});
        exp_q.push_back({4'h2, b1});
        exp_q.push_back({4'h2, b2});
        exp_q.push_back({4'hA, b3});
    endtask

    task automatic push_read(input logic [47:0] bytes);
        exp_q.push_back({4'h3, 8'h71});
        for (int i = 0; i < 6; i++) begin
            rd_q.push_back(bytes[47 - 8*i -: 8]);
            exp_q.push_back((i == 5) ? {4'hC, 8'h00} : {4'h4, 8'h00});
        end
    endtask

    task automatic wait_req(input int n, input int budget, output bit ok);
        int i = 0;
        while (req_cnt < n && i < budget) begin @(posedge clk); i++; end
        ok = (req_cnt >= n);
    endtask

    task automatic wait_vld(input int n, input int budget, output bit ok);
        int i = 0;
        while (vld_cnt < n && i < budget) begin @(posedge clk); i++; end
        ok = (vld_cnt >= n);
    endtask

    task automatic test_reset();
        bit ok;
        int rel;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({i2c_req, i2c_cmd, i2c_wr_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_i2c: got %h required 0", {i2c_req, i2c_cmd, i2c_wr_data});
        end
        checks++;
        if ({dout, dout_vld, err} !== 42'h0) begin
            errors++;
            $display("FAIL reset_out: got %h required 0", {dout, dout_vld, err});
        end
        push_seq(8'hE1, 8'h08, 8'h00);
        @(negedge clk);
        rel = cyc;
        rst_n = 1'b1;
        wait_req(1, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL first_req_timeout: got %0d reqs required 1", req_cnt);
        end else if (req_cyc[0] - rel != PWR_UP_MS) begin
            errors++;
            $display("FAIL first_req_time: got %0d required %0d", req_cyc[0] - rel, PWR_UP_MS);
        end
    endtask

    task automatic test_init_trigger();
        bit ok;
        push_seq(8'hAC, 8'h33, 8'h00);
        wait_req(8, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL trig_timeout: got %0d reqs required 8", req_cnt);
        end else begin
            checks++;
            if (req_cyc[1] != done_cyc[0] + 1) begin
                errors++;
                $display("FAIL req_after_done: got %0d required %0d", req_cyc[1], done_cyc[0] + 1);
            end
            checks++;
            if (req_cyc[4] != done_cyc[3] + 1 + INIT_MS) begin
                errors++;
                $display("FAIL trig_time: got %0d required %0d", req_cyc[4], done_cyc[3] + 1 + INIT_MS);
            end
        end
    endtask

    task automatic test_measure();
        bit ok1, ok2;
        int v;
        push_read(48'h1C_6B_85_A5_E3_9A);
        dout_q.push_back(40'h6B85A_5E39A);
        push_seq(8'hAC, 8'h33, 8'h00);
        wait_vld(1, 500, ok1);
        v = vld_cyc;
        wait_req(19, 2000, ok2);
        checks++;
        if (!(ok1 && ok2)) begin
            errors++;
            $display("FAIL measure_timeout: got vld %0d req %0d required 1 and 19", vld_cnt, req_cnt);
        end else begin
            checks++;
            if (req_cyc[8] != done_cyc[7] + 1 + MEAS_MS) begin
                errors++;
                $display("FAIL read_time: got %0d required %0d", req_cyc[8], done_cyc[7] + 1 + MEAS_MS);
            end
            checks++;
            if (v != done_cyc[14] + 2) begin
                errors++;
                $display("FAIL vld_time: got %0d required %0d", v, done_cyc[14] + 2);
            end
            checks++;
            if (req_cyc[15] != v + PERIOD_MS) begin
                errors++;
                $display("FAIL period_time: got %0d required %0d", req_cyc[15], v + PERIOD_MS);
            end
            checks++;
            if (dout !== 40'h6B85A_5E39A) begin
                errors++;
                $display("FAIL dout_hold: got %h required %h", dout, 40'h6B85A_5E39A);
            end
        end
    endtask

    task automatic test_busy();
        bit ok;
        push_read(48'h9C_11_22_33_44_55);
        push_read(48'h1C_12_34_56_78_9A);
        dout_q.push_back(40'h12345_6789A);
        wait_vld(2, 800, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL busy_timeout: got vld %0d required 2", vld_cnt);
        end else begin
            checks++;
            if (req_cyc[26] != done_cyc[25] + 2 + MEAS_MS) begin
                errors++;
                $display("FAIL reread_time: got %0d required %0d", req_cyc[26], done_cyc[25] + 2 + MEAS_MS);
            end
            checks++;
            if (vld_cyc != done_cyc[32] + 2) begin
                errors++;
                $display("FAIL busy_vld_time: got %0d required %0d", vld_cyc, done_cyc[32] + 2);
            end
        end
    endtask

    task automatic test_nack();
        bit ok;
        int e0 = err_cnt;
        nack_byte = 8'hAC;
        nack_arm  = 1'b1;
        exp_q.push_back({4'h3, 8'h70});
        exp_q.push_back({4'h2, 8'hAC});
        exp_q.push_back({4'h8, 8'h00});
        push_seq(8'hE1, 8'h08, 8'h00);
        wait_req(37, 2000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nack_timeout: got %0d reqs required 37", req_cnt);
        end else begin
            checks++;
            if (err_cnt != e0 + 1) begin
                errors++;
                $display("FAIL nack_err_count: got %0d required %0d", err_cnt, e0 + 1);
            end
            checks++;
            if (req_cyc[35] != done_cyc[34] + 1 || err_cyc != done_cyc[35] + 1) begin
                errors++;
                $display("FAIL abort_time: stop %0d err %0d required %0d %0d",
                         req_cyc[35], err_cyc, done_cyc[34] + 1, done_cyc[35] + 1);
            end
            checks++;
            if (req_cyc[36] != err_cyc + RETRY_MS) begin
                errors++;
                $display("FAIL retry_time: got %0d required %0d", req_cyc[36], err_cyc + RETRY_MS);
            end
        end
    endtask

    task automatic test_uncal();
        bit ok;
        int e0 = err_cnt;
        push_seq(8'hAC, 8'h33, 8'h00);
        push_read(48'h14_AA_BB_CC_DD_EE);
        push_seq(8'hE1, 8'h08, 8'h00);
        wait_req(52, 1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL uncal_timeout: got %0d reqs required 52", req_cnt);
        end else begin
            checks++;
            if (err_cnt != e0 + 1 || err_cyc != done_cyc[50] + 2) begin
                errors++;
                $display("FAIL uncal_err: count %0d cycle %0d required %0d %0d",
                         err_cnt, err_cyc, e0 + 1, done_cyc[50] + 2);
            end
            checks++;
            if (dout !== 40'h12345_6789A || vld_cnt != 2) begin
                errors++;
                $display("FAIL uncal_dout: got %h vld %0d required %h vld 2", dout, vld_cnt, 40'h12345_6789A);
            end
            checks++;
            if (req_cyc[51] != err_cyc + RETRY_MS) begin
                errors++;
                $display("FAIL uncal_retry_time: got %0d required %0d", req_cyc[51], err_cyc + RETRY_MS);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rel, base;
        push_seq(8'hAC, 8'h33, 8'h00);
        push_read(48'h1C_01_02_03_04_05);
        wait_req(64, 1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_timeout: got %0d reqs required 64", req_cnt);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({i2c_req, i2c_cmd, i2c_wr_data, dout, dout_vld, err} !== 55'h0) begin
            errors++;
            $display("FAIL mid_reset_out: got %h required 0", {i2c_req, i2c_cmd, i2c_wr_data, dout, dout_vld, err});
        end
        exp_q.delete();
        rd_q.delete();
        repeat (5) @(posedge clk);
        push_seq(8'hE1, 8'h08, 8'h00);
        @(negedge clk);
        rel  = cyc;
        base = req_cnt;
        rst_n = 1'b1;
        wait_req(base + 4, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL restart_timeout: got %0d reqs required %0d", req_cnt, base + 4);
        end else if (req_cyc[base] - rel != PWR_UP_MS) begin
            errors++;
            $display("FAIL restart_time: got %0d required %0d", req_cyc[base] - rel, PWR_UP_MS);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got %0d checks", checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_init_trigger();
        test_measure();
        test_busy();
        test_nack();
        test_uncal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
